fetch_sequencer: RTL

//  Sequences the combinational instruction ROM for the pipelined CPU. Owns the

---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, reads a combinational instruction
// ROM and queues each {pc, instruction} pair in a 2-entry fetch buffer. The
// buffer head goes to decode over a valid/ready handshake. The block also
// handles redirects from execute and stops fetching at the halt opcode.
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating performance counters
// fetch_cnt (instructions accepted by decode) and flush_cnt (redirects that
// threw away at least one buffered instruction).
module fetch_sequencer #(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [4:0]      HALT_OP  = 5'b11010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redir_valid,
  input  logic [PC_W-1:0]   redir_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic              halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t            state;
  logic [1:0]        count;      // occupied buffer entries, 0..2
  logic [INST_W-1:0] tail_inst;  // second entry; the head lives in inst/inst_pc
  logic [PC_W-1:0]   tail_pc;

  logic       active;
  logic       redir;
  logic       pop;
  logic       push;
  logic       halt_word;
  logic       head_gets_new;
  logic [1:0] count_next;

  // Handshake and buffer bookkeeping shared by the FSM and the counters.
  assign active     = (state == RUN) || (state == DRAIN);
  assign redir      = redir_valid && active;
  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid && inst_ready;
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign push       = (state == RUN) && !redir && ((count != 2'd2) || pop);
  assign halt_word  = (rom_inst[INST_W-1 -: 5] == HALT_OP);
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  // The new word lands in the head slot whenever the head is empty after the pop.
  assign head_gets_new = (count == 2'd0) || ((count == 2'd1) && pop);

  // Fetch FSM, program counter, buffer storage and registered status outputs.
  // NOTE: every register here uses non-blocking assignment so that all of them
  // update from the same pre-edge values; blocking would make the buffer shift
  // and the push order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      count     <= 2'd0;
      inst      <= '0;
      inst_pc   <= '0;
      // NOTE: the tail entry is reset as well; it is only two words, and a
      // defined value keeps reset behaviour identical in simulation and silicon.
      tail_inst <= '0;
      tail_pc   <= '0;
      halted    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state  <= RUN;
            pc     <= RESET_PC;
            halted <= 1'b0;
            busy   <= 1'b1;
          end
        end

        RUN, DRAIN: begin
          if (redir) begin
            // Redirect wins over everything: drop the buffer, including any
            // head decode is taking this cycle, and restart at the target.
            state <= RUN;
            count <= 2'd0;
            pc    <= redir_pc;
          end else begin
            count <= count_next;
            if (pop && (count == 2'd2)) begin
              inst    <= tail_inst;
              inst_pc <= tail_pc;
            end
            if (push) begin
              if (head_gets_new) begin
                inst    <= rom_inst;
                inst_pc <= pc;
              end else begin
                tail_inst <= rom_inst;
                tail_pc   <= pc;
              end
              // The halt word is buffered but pc stays on it.
              if (halt_word) begin
                state <= DRAIN;
              end else begin
                pc <= pc + PC_W'(1);
              end
            end
            // Only pops happen in DRAIN, so the last pop ends the program.
            if ((state == DRAIN) && (count_next == 2'd0)) begin
              state  <= HALTED;
              halted <= 1'b1;
              busy   <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters of accepted instructions and of flushing redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else if (start && !active) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop && !redir && (fetch_cnt != '1)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (redir && inst_valid && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
